// File: rtl/imm_pfx_if.sv
// Decode-stage bundle between the issue logic and the offset-prefix controller.
// The master side presents instructions; the slave side returns offset and select lines.
interface imm_pfx_if #(
    parameter int OF_W = 4
);
    logic            ir_valid;
    logic            stall;
    logic            flush;
    logic            ir_is_pfx;
    logic [OF_W-1:0] pfx_val;
    logic            ir_uses_imm;
    logic            ir_is_lop;
    logic [OF_W-1:0] of_q;
    logic            con_of;
    logic            sel_lop;
    logic            pfx_pending;
    logic            pfx_drop;
    logic            pfx_err;

    modport master (
        output ir_valid, stall, flush, ir_is_pfx, pfx_val, ir_uses_imm, ir_is_lop,
        input  of_q, con_of, sel_lop, pfx_pending, pfx_drop, pfx_err
    );

    modport slave (
        input  ir_valid, stall, flush, ir_is_pfx, pfx_val, ir_uses_imm, ir_is_lop,
        output of_q, con_of, sel_lop, pfx_pending, pfx_drop, pfx_err
    );
endinterface

// File: rtl/imm_prefix_ctrl.sv
// Offset-prefix tracker feeding the immediate generator: arms on a prefix, hands the offset to the next instruction.
// Optional IMM_PFX_STATS_EN adds the saturating drop_cnt output port.
module imm_prefix_ctrl #(
    parameter int OF_W  = 4,
    parameter int TMO   = 8,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    imm_pfx_if.slave        bus
`ifdef IMM_PFX_STATS_EN
    ,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO > 0) ? TMO - 1 : 0);

    state_e           state_q, state_d;
    logic [OF_W-1:0]  of_q, of_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic             accept;
    logic             armed;

    assign accept = bus.ir_valid & ~bus.stall & ~bus.flush;
    assign armed  = (state_q == ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            of_q    <= '0;
            tmo_q   <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            of_q    <= of_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    // Flush outranks everything and is silent; a stall freezes state but still lets pulses retire.
    always_comb begin
        state_d = state_q;
        of_d    = of_q;
        tmo_d   = tmo_q;
        drop_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            of_d    = '0;
            tmo_d   = '0;
        end else if (!bus.stall) begin
            unique case (state_q)
                IDLE: begin
                    if (accept && bus.ir_is_pfx) begin
                        state_d = ARMED;
                        of_d    = bus.pfx_val;
                        tmo_d   = '0;
                    end
                end
                ARMED: begin
                    if (accept && bus.ir_is_pfx) begin
                        of_d  = bus.pfx_val;
                        tmo_d = '0;
                        err_d = 1'b1;
                    end else if (accept) begin
                        state_d = IDLE;
                        of_d    = '0;
                        tmo_d   = '0;
                        drop_d  = ~(bus.ir_uses_imm | bus.ir_is_lop);
                    end else if (TMO != 0) begin
                        if (tmo_q == TMO_LAST) begin
                            state_d = IDLE;
                            of_d    = '0;
                            tmo_d   = '0;
                            drop_d  = 1'b1;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Selects are combinational so the consumer sees them in its own decode cycle, even while stalled.
    assign bus.con_of      = armed & bus.ir_valid & bus.ir_uses_imm & ~bus.ir_is_lop & ~bus.ir_is_pfx;
    assign bus.sel_lop     = armed & bus.ir_valid & bus.ir_is_lop & ~bus.ir_is_pfx;
    assign bus.of_q        = of_q;
    assign bus.pfx_pending = armed;
    assign bus.pfx_drop    = drop_q;
    assign bus.pfx_err     = err_q;

`ifdef IMM_PFX_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drop_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt = cnt_q;
`endif

endmodule
